// File: rtl/bus_select_reg.sv
// bus_select_reg: registered N:1 bus select driven by one-hot out strobes.
// Define BUS_SELECT_CONFLICT_CHECK_EN to add the multi-driver flag and counter.
module bus_select_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SELW  = $clog2(N),
  parameter int CNTW  = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [N*WIDTH-1:0] src_data,
  input  logic [N-1:0]       src_out,
  input  logic               bus_en,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   bus_out,
  output logic [SELW-1:0]    bus_sel,
  output logic               bus_valid,
  output logic               conflict,
  output logic [CNTW-1:0]    conflict_cnt
);

  logic             w_any;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_word;

  // Priority encoder: scanning high to low lets the lowest set bit win.
  always_comb begin
    w_any  = |src_out;
    w_idx  = '0;
    w_word = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        w_idx  = SELW'(i);
        w_word = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Bus word, select and valid strobe; idle or disabled cycles hold the bus.
  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out   <= '0;
      bus_sel   <= '0;
      bus_valid <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      if (bus_en && w_any) begin
        bus_out   <= w_word;
        bus_sel   <= w_idx;
        bus_valid <= 1'b1;
      end
    end
  end

`ifdef BUS_SELECT_CONFLICT_CHECK_EN
  logic w_multi;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi = |(src_out & (src_out - N'(1)));

  // Sticky flag and saturating counter; a conflict beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (bus_en && w_multi) begin
      conflict <= 1'b1;
      if (err_clr)
        conflict_cnt <= CNTW'(1);
      else if (conflict_cnt != {CNTW{1'b1}})
        conflict_cnt <= conflict_cnt + CNTW'(1);
    end else if (bus_en && err_clr) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end
  end
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign conflict         = 1'b0;
  assign conflict_cnt     = '0;
`endif

endmodule

// File: doc/bus_select_reg.md
# bus_select_reg

Parametrised, registered successor to the datapath's 32:1 bus multiplexer. Takes N source words and a one-hot drive-enable vector (the per-register "out" strobes) and encodes the vector internally. Registers the selected word onto the shared bus with one cycle of latency, and detects and counts illegal multi-driver cycles. Sits between the register file / special registers (HI, LO, Z, PC, MDR, port, C) and the bus consumers (ALU inputs, MAR, MDR, register inputs).

## Interface
- WIDTH, 32, bus and source word width in bits
- N, 32, number of sources; 2..64
- SELW, $clog2(N), width of encoded select
- CNTW, 8, width of conflict counter

- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- src_data  in  N*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
- src_out  in  N  drive enables; bit i requests source i onto bus
- bus_en  in  1  capture enable; 0 freezes all state except valid
- err_clr  in  1  clears sticky conflict flag and counter
- bus_out  out  WIDTH  registered bus word
- bus_sel  out  SELW  registered index of the source currently on bus
- bus_valid  out  1  high for one cycle after a single-driver (or resolved) capture
- conflict  out  1  sticky; set on any capture with ≥2 src_out bits
- conflict_cnt  out  CNTW  saturating count of conflict captures

## Operation
- Encoder: priority encode src_out; lowest set index wins. popcount classes: none, one, many.
- Capture cycle (bus_en=1):
  - one: bus_out←src_data[idx], bus_sel←idx, bus_valid←1.
  - many: same as one using lowest index; conflict←1; conflict_cnt←conflict_cnt+1, saturating at 2^CNTW−1.
  - none: bus_out and bus_sel hold; bus_valid←0.
- bus_en=0: bus_out, bus_sel, conflict, conflict_cnt hold; bus_valid←0. src_out ignored entirely.
- err_clr=1: conflict←0, conflict_cnt←0, unless the same cycle is a conflict capture. In that case conflict←1 and conflict_cnt←1 (the new event is preserved).
- Source indices ≥N cannot occur; src_out is exactly N bits wide.
- No state machine beyond registers. Counter and sticky flag are the only accumulating state.

## Timing
- Latency: src_data/src_out sampled at edge k; bus_out valid after edge k (visible in cycle k+1).
- Throughput: one capture per cycle; back-to-back different sources allowed.
- Reset (clear=1 at an edge): bus_out=0, bus_sel=0, bus_valid=0, conflict=0, conflict_cnt=0. Takes priority over bus_en and err_clr.
- Reset mid-stream: the capture on the reset edge is discarded. The next edge with clear=0 resumes normally.
- Saturation: at conflict_cnt=2^CNTW−1, further conflicts leave the count unchanged and conflict stays 1.
- All outputs are driven directly from flops. No combinational path exists from inputs to outputs.

## Configuration
- BUS_SELECT_CONFLICT_CHECK_EN defined: popcount/conflict logic present; conflict and conflict_cnt behave as above.
- Not defined: no popcount logic. conflict and conflict_cnt are tied to 0, and err_clr is ignored. Multi-hot src_out still resolves to the lowest index with bus_valid=1.

## Test plan
- Reset: drive clear=1 with src_out=1<<5, bus_en=1 -> after edge, all outputs 0. Release clear -> next edge bus_out=src_data[5], bus_sel=5, bus_valid=1.
- Single drivers back-to-back: src_out=1<<20 (PC=0x0000_0100), then 1<<21 (MDR=0xDEAD_BEEF) on consecutive edges -> bus_out follows one cycle later: 0x100/sel 20, then 0xDEADBEEF/sel 21. bus_valid=1 both cycles, conflict=0.
- Idle/hold: after capturing 0xDEADBEEF, drive src_out=0 for 3 cycles -> bus_out stays 0xDEADBEEF and bus_sel=21 with bus_valid=0. Repeat with bus_en=0 and src_out=1<<3 -> same hold.
- Conflict: src_out=(1<<3)|(1<<17) -> bus_out=src_data[3], bus_sel=3, conflict=1, conflict_cnt=1. Single-driver capture next -> conflict stays 1.
- Saturation and clear: apply 300 conflict captures -> conflict_cnt=255. err_clr=1 with src_out=1<<0 -> cnt=0, conflict=0. err_clr=1 coincident with conflict -> cnt=1, conflict=1.
- Macro off: repeat the conflict scenario -> bus_out=src_data[3], bus_valid=1, conflict=0, conflict_cnt=0. Run with N=8, WIDTH=16 to confirm parametrisation.
